// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: FSM states, funct3 codes, store lane helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    // RISC-V load/store width codes (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // sz is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        return ((sz == 2'b01) && off[0]) || ((sz == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Narrow stores replicate the datum so every enabled lane already holds it
    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of EX-side, data-memory-side and writeback-side signals of the memory access unit.
// Latency: n/a (wiring only).
// Backpressure: ex_valid/ex_ready handshake on the EX side, dmem_req/dmem_gnt on the memory side.
// Modports: slave = the unit itself, master = the environment (EX stage, memory, writeback).
interface mem_access_unit_if;
    // EX stage
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        flush;
    // data memory
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    // writeback
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign_exc;

    modport slave (
        input  ex_valid, alu_out, store_data, is_load, is_store, funct3, rd, reg_write, flush,
        output ex_ready,
        output dmem_req, dmem_addr, dmem_we, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output wb_valid, wb_data, wb_rd, wb_reg_write, misalign_exc
    );

    modport master (
        output ex_valid, alu_out, store_data, is_load, is_store, funct3, rd, reg_write, flush,
        input  ex_ready,
        input  dmem_req, dmem_addr, dmem_we, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  wb_valid, wb_data, wb_rd, wb_reg_write, misalign_exc
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half of a load word and zero/sign-extends it per funct3.
// Latency: combinational.
// Backpressure: none.
// Ports: rdata (memory word), offset (address[1:0]), funct3 (width/sign), value (extended result).
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        value  = rdata;
        case (funct3)
            F3_LB:   value = {{24{lane_b[7]}}, lane_b};
            F3_LH:   value = {{16{lane_h[15]}}, lane_h};
            F3_LBU:  value = {24'h0, lane_b};
            F3_LHU:  value = {16'h0, lane_h};
            default: value = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Executes one load/store/pass-through op at a time against a req/gnt data memory and writes back.
// Latency: pass-through/misaligned 1 cycle; store 1 + grant wait; load 1 + grant wait + response wait.
// Backpressure: ex_ready only in IDLE; request held stable until dmem_gnt.
// Ports: clk, rst (async active-high), bus (mem_access_unit_if.slave: EX, dmem and writeback groups).
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    state_t      state_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic        store_q;
    logic        cancel_q;

    logic        dmem_req_q;
    logic [31:0] dmem_addr_q;
    logic [3:0]  dmem_we_q;
    logic [31:0] dmem_wdata_q;
    logic        wb_valid_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        wb_reg_write_q;
    logic        misalign_q;

    logic        accept;
    logic        misaligned;
    logic [31:0] ld_val;

    assign accept     = bus.ex_valid && (state_q == IDLE) && !bus.flush;
    assign misaligned = is_misaligned(bus.funct3[1:0], bus.alu_out[1:0]);

    load_extend u_load_extend (
        .rdata  (bus.dmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .value  (ld_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            f3_q           <= 3'b000;
            off_q          <= 2'b00;
            rd_q           <= 5'd0;
            rw_q           <= 1'b0;
            store_q        <= 1'b0;
            cancel_q       <= 1'b0;
            dmem_req_q     <= 1'b0;
            dmem_addr_q    <= 32'h0;
            dmem_we_q      <= 4'h0;
            dmem_wdata_q   <= 32'h0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= 32'h0;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            // writeback strobes are single-cycle pulses out of DONE
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            misalign_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        f3_q     <= bus.funct3;
                        off_q    <= bus.alu_out[1:0];
                        rd_q     <= bus.rd;
                        rw_q     <= bus.reg_write;
                        store_q  <= bus.is_store;
                        cancel_q <= 1'b0;
                        if (!bus.is_load && !bus.is_store) begin
                            state_q        <= DONE;
                            wb_valid_q     <= 1'b1;
                            wb_data_q      <= bus.alu_out;
                            wb_rd_q        <= bus.rd;
                            wb_reg_write_q <= bus.reg_write;
                        end else if (misaligned) begin
                            // report the faulting address as the writeback data
                            state_q        <= DONE;
                            wb_valid_q     <= 1'b1;
                            wb_data_q      <= bus.alu_out;
                            wb_rd_q        <= bus.rd;
                            misalign_q     <= 1'b1;
                        end else begin
                            state_q      <= REQ;
                            dmem_req_q   <= 1'b1;
                            dmem_addr_q  <= {bus.alu_out[31:2], 2'b00};
                            dmem_we_q    <= bus.is_store ? store_be(bus.funct3[1:0], bus.alu_out[1:0]) : 4'h0;
                            dmem_wdata_q <= bus.is_store ? store_wdata(bus.funct3[1:0], bus.store_data) : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (bus.dmem_gnt) begin
                        // grant beats a same-cycle flush: the access is already committed
                        dmem_req_q <= 1'b0;
                        if (store_q) begin
                            if (bus.flush) begin
                                state_q <= IDLE;
                            end else begin
                                state_q    <= DONE;
                                wb_valid_q <= 1'b1;
                                wb_data_q  <= 32'h0;
                                wb_rd_q    <= rd_q;
                            end
                        end else begin
                            // a granted load still owes a response; drain it cancelled
                            state_q  <= WAIT_RESP;
                            cancel_q <= bus.flush;
                        end
                    end else if (bus.flush) begin
                        dmem_req_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                WAIT_RESP: begin
                    if (bus.dmem_rvalid) begin
                        cancel_q <= 1'b0;
                        if (cancel_q || bus.flush) begin
                            state_q <= IDLE;
                        end else begin
                            state_q        <= DONE;
                            wb_valid_q     <= 1'b1;
                            wb_data_q      <= ld_val;
                            wb_rd_q        <= rd_q;
                            wb_reg_write_q <= rw_q;
                        end
                    end else if (bus.flush) begin
                        cancel_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ex_ready     = (state_q == IDLE);
    assign bus.dmem_req     = dmem_req_q;
    assign bus.dmem_addr    = dmem_addr_q;
    assign bus.dmem_we      = dmem_we_q;
    assign bus.dmem_wdata   = dmem_wdata_q;
    // The strobes are only ever high while in DONE, so a flush arriving during DONE
    // has to kill them in that same cycle; that needs this one gate after the flop.
    assign bus.wb_valid     = wb_valid_q && !bus.flush;
    assign bus.misalign_exc = misalign_q && !bus.flush;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_reg_write = wb_reg_write_q;
endmodule
